fp_unified_alu: RTL
===================

FP_UNIFIED_ALU -- requirements
Module: fp_unified_alu

Interface
REQ-001 Parameter EXP_W, default 6, exponent width; bias BIAS = 2^(EXP_W-1)-1.
REQ-002 Parameter MAN_W, default 22, mantissa width; SHALL satisfy MAN_W >= 2*MUL_W.
REQ-003 Parameter MUL_W, default 11, number of mantissa MSBs used by the multiplier.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 op  input  2  operation: 00 ADD, 01 SUB (A-B), 10 MUL, 11 PASS (normalise A).
REQ-009 a_sgn, b_sgn  input  1 each  operand signs.
REQ-010 a_exp, b_exp  input  EXP_W each  biased exponents.
REQ-011 a_man, b_man  input  MAN_W each  left-aligned fractions, not necessarily normalised; value = (-1)^s * 0.M * 2^(E-BIAS).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 y_sgn, y_exp, y_man  output  1/EXP_W/MAN_W  normalised result.
REQ-015 y_zero, y_ovf, y_unf  output  1 each  flags: zero result, exponent saturated high, flushed to zero.

Function
REQ-016 A beat transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.
REQ-017 Pipeline depth SHALL be 4 stages: exponent compare/multiply, align, add, normalise/exponent adjust; unstalled latency is exactly 4 cycles from accept to out_valid.
REQ-018 Global stall: advance = ~out_valid | out_ready; in_ready = advance; while stalled, every stage register and output SHALL hold.
REQ-019 Each stage SHALL carry a valid bit; bubbles SHALL flow through without asserting out_valid; 100% throughput when out_ready is held high.
REQ-020 SUB SHALL be identical to ADD with b_sgn inverted at stage 1.
REQ-021 ADD: smaller-exponent mantissa right-shifted by |a_exp-b_exp| with zero fill; shift >= MAN_W yields 0; effective op = add if signs equal, else subtract.
REQ-022 ADD effective-subtract: result = larger magnitude minus smaller; y_sgn = sign of the larger-magnitude operand.
REQ-023 ADD carry-out: mantissa right-shifted 1 with the carry as MSB, exponent +1.
REQ-024 A zero mantissa (all bits 0) SHALL NOT set the exponent: result = other operand, normalised; for ADD with both zero, or exact cancellation, result is +0.
REQ-025 MUL: product of a_man[MAN_W-1 -: MUL_W] and b_man[MAN_W-1 -: MUL_W], left-aligned into MAN_W (low bits zero); y_sgn = a_sgn ^ b_sgn; exponent = a_exp + b_exp - BIAS.
REQ-026 Normalise: left-shift by leading-zero count until MSB = 1; exponent reduced by the same count.
REQ-027 Exponent arithmetic SHALL use a signed EXP_W+2-bit intermediate.
REQ-028 Truncation only, no rounding; discarded shifted-out bits are lost.
REQ-029 Final exponent > 2^EXP_W-1: y_exp = all ones, y_man = all ones, y_ovf = 1.
REQ-030 Final exponent < 0: y_man = 0, y_exp = 0, y_sgn = 0, y_unf = 1, y_zero = 1.
REQ-031 Zero result: y_man = 0, y_exp = 0, y_sgn = 0, y_zero = 1; flags are mutually consistent and valid only with out_valid.
REQ-032 PASS: A normalised per REQ-026/029/030; B ignored.
REQ-033 op and operands SHALL be sampled only on an accepted beat and travel with it; op changes between beats SHALL not affect in-flight results.

Reset
REQ-034 rst_n low at a clock edge SHALL clear all stage valid bits and outputs: out_valid = 0, y_* = 0, flags = 0; in_ready = 1 on the first cycle after reset release.
REQ-035 Reset mid-operation SHALL discard all in-flight beats; no result for them SHALL appear after reset release.
REQ-036 Datapath registers other than valid bits and outputs need not be reset.

Verification (defaults, BIAS = 31, hex mantissas)
REQ-037 ADD a=(0,31,200000) b=(0,31,200000), out_ready=1 -> 4 cycles later y=(0,32,200000), flags 0.
REQ-038 SUB a=(0,31,300000) b=(0,31,200000) -> y=(0,30,200000); SUB a=b=(0,40,2AAAAA) -> y=(0,0,000000), y_zero=1.
REQ-039 MUL a=(0,32,200000) b=(1,33,300000) -> y=(1,33,300000); ADD a=(0,50,000000) b=(0,10,200000) -> y=(0,10,200000).
REQ-040 ADD a=b=(0,63,200000) -> y=(0,63,3FFFFF), y_ovf=1; MUL a=b=(0,1,200000) -> y_unf=1, y_zero=1.
REQ-041 Stream 8 back-to-back beats, out_ready low for cycles 3-9 -> in_ready low while full, all 8 results emerge in order, none lost or duplicated; rst_n low for one cycle mid-stream -> out_valid = 0 the next cycle, no stale results.

Source files
------------

// File: rtl/fp_unified_alu.sv
// fp_unified_alu: four-stage pipelined floating-point ADD / SUB / MUL / PASS unit.
//
// Number format: sign, biased exponent (bias 2^(EXP_W-1)-1) and a left-aligned fraction,
// value = (-1)^s * 0.M * 2^(E-bias). Input fractions need not be normalised; results are
// normalised (MSB of y_man set) unless zero, underflowed or saturated. Truncation only.
//
// Pipeline: stage 1 exponent compare / multiply, stage 2 align, stage 3 add/subtract,
// stage 4 normalise and exponent adjust into the output registers. A single global
// stall (advance) freezes every stage while a result waits on out_ready.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         operand beat handshake
//   op                          00 ADD, 01 SUB (A-B), 10 MUL, 11 PASS (normalise A)
//   a_sgn/a_exp/a_man, b_*      operands
//   out_valid / out_ready       result handshake
//   y_sgn/y_exp/y_man           normalised result
//   y_zero, y_ovf, y_unf        zero result, exponent saturated high, flushed to zero
//
// MAN_W must be at least 2*MUL_W so the full product fits the fraction.
module fp_unified_alu #(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 22,
  parameter int unsigned MUL_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             a_sgn,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic             b_sgn,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y_sgn,
  output logic [EXP_W-1:0] y_exp,
  output logic [MAN_W-1:0] y_man,
  output logic             y_zero,
  output logic             y_ovf,
  output logic             y_unf
);

  // Signed exponent intermediate, wide enough for a_exp + b_exp - bias and normalise shifts.
  localparam int unsigned ExpIW = EXP_W + 2;
  localparam int unsigned LzW   = $clog2(MAN_W + 1);
  localparam int unsigned ProdW = 2 * MUL_W;

  localparam logic signed [ExpIW-1:0] Bias   = ExpIW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [ExpIW-1:0] ExpMax = ExpIW'((1 << EXP_W) - 1);
  localparam logic signed [ExpIW-1:0] ExpOne = ExpIW'(1);

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpMul  = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  // Leading-zero count; an all-zero input returns MAN_W.
  function automatic logic [LzW-1:0] lzc(input logic [MAN_W-1:0] v);
    logic [LzW-1:0] cnt;
    logic           found;
    cnt   = '0;
    found = 1'b0;
    for (int i = int'(MAN_W) - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          cnt = cnt + LzW'(1);
        end
      end
    end
    return cnt;
  endfunction

  logic advance;

  // ---------------------------------------------------------------------------------------
  // Stage 1: exponent compare / multiply
  // ---------------------------------------------------------------------------------------
  // Every op is mapped onto "x +/- (y >> shamt)" with exponent exp. MUL, PASS and ADD with a
  // zero operand become single-operand beats (y = 0) and only use the normaliser.
  logic signed [ExpIW-1:0] a_exp_s, b_exp_s, exp_ab, exp_ba;
  logic [ProdW-1:0]        prod;
  logic                    b_sgn_eff;

  logic                    s1_valid_q;
  logic                    s1_sub_d, s1_sub_q;
  logic                    s1_sgn_x_d, s1_sgn_x_q;
  logic                    s1_sgn_y_d, s1_sgn_y_q;
  logic signed [ExpIW-1:0] s1_exp_d, s1_exp_q;
  logic [ExpIW-1:0]        s1_shamt_d, s1_shamt_q;
  logic [MAN_W-1:0]        s1_man_x_d, s1_man_x_q;
  logic [MAN_W-1:0]        s1_man_y_d, s1_man_y_q;

  always_comb begin
    a_exp_s   = $signed({2'b00, a_exp});
    b_exp_s   = $signed({2'b00, b_exp});
    exp_ab    = a_exp_s - b_exp_s;
    exp_ba    = b_exp_s - a_exp_s;
    b_sgn_eff = b_sgn ^ (op == OpSub);
    prod      = a_man[MAN_W-1 -: MUL_W] * b_man[MAN_W-1 -: MUL_W];

    s1_sub_d   = 1'b0;
    s1_sgn_x_d = a_sgn;
    s1_sgn_y_d = b_sgn_eff;
    s1_exp_d   = a_exp_s;
    s1_shamt_d = '0;
    s1_man_x_d = a_man;
    s1_man_y_d = '0;

    case (op)
      OpAdd, OpSub: begin
        if (a_man == '0) begin
          // A zero fraction carries no exponent information: result is B alone.
          s1_sgn_x_d = b_sgn_eff;
          s1_exp_d   = b_exp_s;
          s1_man_x_d = b_man;
        end else if (b_man == '0) begin
          // A alone (defaults).
        end else if (!exp_ab[ExpIW-1]) begin
          s1_sub_d   = a_sgn ^ b_sgn_eff;
          s1_shamt_d = exp_ab;
          s1_man_y_d = b_man;
        end else begin
          s1_sub_d   = a_sgn ^ b_sgn_eff;
          s1_sgn_x_d = b_sgn_eff;
          s1_sgn_y_d = a_sgn;
          s1_exp_d   = b_exp_s;
          s1_shamt_d = exp_ba;
          s1_man_x_d = b_man;
          s1_man_y_d = a_man;
        end
      end
      OpMul: begin
        s1_sgn_x_d = a_sgn ^ b_sgn;
        s1_exp_d   = a_exp_s + b_exp_s - Bias;
        s1_man_x_d = MAN_W'(prod) << (MAN_W - ProdW);
      end
      OpPass: begin
        s1_man_x_d = a_man;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Stage 2: align the smaller-exponent fraction
  // ---------------------------------------------------------------------------------------
  logic                    s2_valid_q;
  logic                    s2_sub_q;
  logic                    s2_sgn_x_q, s2_sgn_y_q;
  logic signed [ExpIW-1:0] s2_exp_q;
  logic [MAN_W-1:0]        s2_man_x_q;
  logic [MAN_W-1:0]        s2_man_y_d, s2_man_y_q;

  always_comb begin
    if (32'(s1_shamt_q) >= MAN_W) begin
      s2_man_y_d = '0;
    end else begin
      s2_man_y_d = s1_man_y_q >> s1_shamt_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage 3: add / subtract with one carry bit
  // ---------------------------------------------------------------------------------------
  logic [MAN_W:0]          ext_x, ext_y, diff;
  logic                    s3_valid_q;
  logic                    s3_sgn_d, s3_sgn_q;
  logic signed [ExpIW-1:0] s3_exp_q;
  logic [MAN_W:0]          s3_man_d, s3_man_q;

  always_comb begin
    ext_x    = {1'b0, s2_man_x_q};
    ext_y    = {1'b0, s2_man_y_q};
    diff     = ext_x - ext_y;
    s3_sgn_d = s2_sgn_x_q;
    if (!s2_sub_q) begin
      s3_man_d = ext_x + ext_y;
    end else if (diff[MAN_W]) begin
      // y had the larger magnitude despite the smaller-or-equal exponent.
      s3_man_d = ext_y - ext_x;
      s3_sgn_d = s2_sgn_y_q;
    end else begin
      s3_man_d = diff;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage 4: normalise, exponent adjust, saturate / flush
  // ---------------------------------------------------------------------------------------
  logic [LzW-1:0]          lz;
  logic [MAN_W-1:0]        norm_man;
  logic signed [ExpIW-1:0] norm_exp;
  logic                    y_sgn_d, y_zero_d, y_ovf_d, y_unf_d;
  logic [EXP_W-1:0]        y_exp_d;
  logic [MAN_W-1:0]        y_man_d;

  always_comb begin
    lz = lzc(s3_man_q[MAN_W-1:0]);
    if (s3_man_q[MAN_W]) begin
      // Carry out: shift right one with the carry becoming the MSB.
      norm_man = s3_man_q[MAN_W:1];
      norm_exp = s3_exp_q + ExpOne;
    end else begin
      norm_man = s3_man_q[MAN_W-1:0] << lz;
      norm_exp = s3_exp_q - $signed(ExpIW'(lz));
    end

    y_sgn_d  = s3_sgn_q;
    y_exp_d  = norm_exp[EXP_W-1:0];
    y_man_d  = norm_man;
    y_zero_d = 1'b0;
    y_ovf_d  = 1'b0;
    y_unf_d  = 1'b0;

    if (s3_man_q == '0) begin
      // Zero, including exact cancellation, is always +0.
      y_sgn_d  = 1'b0;
      y_exp_d  = '0;
      y_man_d  = '0;
      y_zero_d = 1'b1;
    end else if (norm_exp > ExpMax) begin
      y_exp_d = '1;
      y_man_d = '1;
      y_ovf_d = 1'b1;
    end else if (norm_exp[ExpIW-1]) begin
      y_sgn_d  = 1'b0;
      y_exp_d  = '0;
      y_man_d  = '0;
      y_zero_d = 1'b1;
      y_unf_d  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Handshake and state
  // ---------------------------------------------------------------------------------------
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Only valid bits and outputs are reset; payload registers just follow advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      y_sgn      <= 1'b0;
      y_exp      <= '0;
      y_man      <= '0;
      y_zero     <= 1'b0;
      y_ovf      <= 1'b0;
      y_unf      <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_sub_q   <= s1_sub_d;
      s1_sgn_x_q <= s1_sgn_x_d;
      s1_sgn_y_q <= s1_sgn_y_d;
      s1_exp_q   <= s1_exp_d;
      s1_shamt_q <= s1_shamt_d;
      s1_man_x_q <= s1_man_x_d;
      s1_man_y_q <= s1_man_y_d;

      s2_valid_q <= s1_valid_q;
      s2_sub_q   <= s1_sub_q;
      s2_sgn_x_q <= s1_sgn_x_q;
      s2_sgn_y_q <= s1_sgn_y_q;
      s2_exp_q   <= s1_exp_q;
      s2_man_x_q <= s1_man_x_q;
      s2_man_y_q <= s2_man_y_d;

      s3_valid_q <= s2_valid_q;
      s3_sgn_q   <= s3_sgn_d;
      s3_exp_q   <= s2_exp_q;
      s3_man_q   <= s3_man_d;

      out_valid  <= s3_valid_q;
      y_sgn      <= y_sgn_d;
      y_exp      <= y_exp_d;
      y_man      <= y_man_d;
      y_zero     <= y_zero_d;
      y_ovf      <= y_ovf_d;
      y_unf      <= y_unf_d;
    end
  end

endmodule
